video_timing: RTL and testbench

Raster timing generator that drives the pixel-coordinate and blanking interface consumed by the pattern and background generators: 11-bit `VX`/`VY` coordinates, `VIDEN` active-video qualifier, and `HSYNC`/`VSYNC` to the DAC/connector. It is the source end of that interface. It sits between the pixel clock domain root and all pixel-colour producers. All outputs are registered and mutually aligned, so a combinational colour stage can use them directly.

---
 rtl/video_pkg.sv | 30 +++
 rtl/timing_axis.sv | 72 +++++++
 rtl/video_timing.sv | 82 ++++++++
 tb/tb_video_timing.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster-timing definitions: axis state encoding, coordinate width and
// the 640x480@60 default timing used by the timing generator and colour stages.
package video_pkg;

   localparam int COORD_W   = 11;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam bit DEF_HS_POL   = 1'b0;
   localparam bit DEF_VS_POL   = 1'b0;

   typedef enum logic [1:0] {
      AX_ACTIVE = 2'd0,
      AX_FRONT  = 2'd1,
      AX_SYNC   = 2'd2,
      AX_BACK   = 2'd3
   } axis_state_t;

   function automatic int axis_total(input int a, input int f, input int s, input int b);
      return a + f + s + b;
   endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a position counter walking ACTIVE -> FRONT -> SYNC -> BACK,
// advancing on adv. The vertical instance is advanced by the horizontal wrap.
module timing_axis
   import video_pkg::*;
#(
   parameter int ACTIVE = DEF_H_ACTIVE,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC   = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP,
   parameter bit POL    = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               adv,
   output logic [COORD_W-1:0] count,
   output logic               active_nxt,
   output logic               sync,
   output logic               wrap
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [COORD_W-1:0] A_END = COORD_W'(ACTIVE - 1);
   localparam logic [COORD_W-1:0] F_END = COORD_W'(ACTIVE + FP - 1);
   localparam logic [COORD_W-1:0] S_END = COORD_W'(ACTIVE + FP + SYNC - 1);
   localparam logic [COORD_W-1:0] LAST  = COORD_W'(TOTAL - 1);

   if (FP < 1 || SYNC < 1 || BP < 1 || TOTAL > COORD_MAX) begin : g_param_err
      $error("timing_axis: porch/sync must be >= 1 and total must fit the coordinate width");
   end

   axis_state_t        state_q, state_d;
   logic [COORD_W-1:0] count_q, count_d;
   logic               sync_q, sync_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= AX_BACK;
         count_q <= LAST;
         sync_q  <= ~POL;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         sync_q  <= sync_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (adv) begin
         count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
         case (state_q)
            AX_ACTIVE: if (count_q == A_END) state_d = AX_FRONT;
            AX_FRONT:  if (count_q == F_END) state_d = AX_SYNC;
            AX_SYNC:   if (count_q == S_END) state_d = AX_BACK;
            AX_BACK:   if (count_q == LAST)  state_d = AX_ACTIVE;
            default:   state_d = AX_BACK;
         endcase
      end
   end

   // Flags are decoded from the next state so they land on the same edge as count.
   always_comb begin
      active_nxt = (state_d == AX_ACTIVE);
      sync_d     = (state_d == AX_SYNC) ? POL : ~POL;
   end

   assign count = count_q;
   assign sync  = sync_q;
   assign wrap  = adv && (count_q == LAST);

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: registered VX/VY coordinates with aligned blanking,
// sync and start-of-line/frame pulses, all advancing only when pix_en is high.
module video_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = DEF_HS_POL,
   parameter bit VS_POL   = DEF_VS_POL
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_en,
   output logic [COORD_W-1:0] VX,
   output logic [COORD_W-1:0] VY,
   output logic               VIDEN,
   output logic               HSYNC,
   output logic               VSYNC,
   output logic               LINE_START,
   output logic               FRAME_START
);

   logic h_active_nxt, v_active_nxt;
   logic h_wrap, v_wrap;
   logic viden_q, viden_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;

   timing_axis #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
   ) u_h_axis (
      .clk       (clk),
      .reset     (reset),
      .adv       (pix_en),
      .count     (VX),
      .active_nxt(h_active_nxt),
      .sync      (HSYNC),
      .wrap      (h_wrap)
   );

   timing_axis #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
   ) u_v_axis (
      .clk       (clk),
      .reset     (reset),
      .adv       (h_wrap),
      .count     (VY),
      .active_nxt(v_active_nxt),
      .sync      (VSYNC),
      .wrap      (v_wrap)
   );

   // Pulses hold while pix_en is low so each one covers a pixel, not a clock.
   always_comb begin
      viden_d       = h_active_nxt && v_active_nxt;
      line_start_d  = pix_en ? h_wrap : line_start_q;
      frame_start_d = pix_en ? (h_wrap && v_wrap) : frame_start_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         viden_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         viden_q       <= viden_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign VIDEN       = viden_q;
   assign LINE_START  = line_start_q;
   assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: three instances (default 640x480, a tiny raster for
// whole-frame checks, 1024x768 high-active sync) against a coordinate model.
module tb_video_timing;

   // Default raster
   localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
   localparam int A_HT = 800, A_VT = 525;
   // Tiny raster: 12 x 7 = 84 pixels per frame
   localparam int B_HA = 8, B_HF = 1, B_HS = 2, B_HB = 1;
   localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
   localparam int B_HT = 12, B_VT = 7;
   // Wide raster with high-active syncs
   localparam int C_HA = 1024, C_HF = 16, C_HS = 96, C_HB = 48;
   localparam int C_VA = 768,  C_VF = 10, C_VS = 2,  C_VB = 33;
   localparam int C_HT = 1184, C_VT = 813;

   logic clk = 1'b0;
   logic reset;
   logic pix_en;

   logic [10:0] a_vx, a_vy, b_vx, b_vy, c_vx, c_vy;
   logic a_viden, a_hsync, a_vsync, a_ls, a_fs;
   logic b_viden, b_hsync, b_vsync, b_ls, b_fs;
   logic c_viden, c_hsync, c_vsync, c_ls, c_fs;

   int n_checks = 0;
   int n_fail   = 0;

   logic [26:0] exp_a_q[$];
   logic [26:0] exp_b_q[$];
   logic [26:0] exp_c_q[$];

   int ax, ay, bx, by, cx, cy;
   bit model_on = 1'b0;

   always #5 clk = ~clk;

   video_timing u_dut_a (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .VX(a_vx), .VY(a_vy), .VIDEN(a_viden), .HSYNC(a_hsync), .VSYNC(a_vsync),
      .LINE_START(a_ls), .FRAME_START(a_fs)
   );

   video_timing #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut_b (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .VX(b_vx), .VY(b_vy), .VIDEN(b_viden), .HSYNC(b_hsync), .VSYNC(b_vsync),
      .LINE_START(b_ls), .FRAME_START(b_fs)
   );

   video_timing #(
      .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
      .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut_c (
      .clk(clk), .reset(reset), .pix_en(pix_en),
      .VX(c_vx), .VY(c_vy), .VIDEN(c_viden), .HSYNC(c_hsync), .VSYNC(c_vsync),
      .LINE_START(c_ls), .FRAME_START(c_fs)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs follow purely from the presented coordinate.
   function automatic logic [26:0] model_out(input int x, input int y,
                                             input int ha, input int hf, input int hs,
                                             input int va, input int vf, input int vs,
                                             input bit hp, input bit vp);
      logic viden, hsy, vsy, ls, fs;
      viden = (x < ha) && (y < va);
      hsy   = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
      vsy   = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
      ls    = (x == 0);
      fs    = (x == 0) && (y == 0);
      return {fs, ls, vsy, hsy, viden, 11'(y), 11'(x)};
   endfunction

   task automatic step_xy(inout int x, inout int y, input int ht, input int vt);
      if (x == ht - 1) begin
         x = 0;
         y = (y == vt - 1) ? 0 : y + 1;
      end else begin
         x = x + 1;
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         ax = A_HT - 1; ay = A_VT - 1;
         bx = B_HT - 1; by = B_VT - 1;
         cx = C_HT - 1; cy = C_VT - 1;
         model_on = 1'b1;
      end else if (pix_en && model_on) begin
         step_xy(ax, ay, A_HT, A_VT);
         step_xy(bx, by, B_HT, B_VT);
         step_xy(cx, cy, C_HT, C_VT);
      end
      if (model_on) begin
         exp_a_q.push_back(model_out(ax, ay, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 1'b0, 1'b0));
         exp_b_q.push_back(model_out(bx, by, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b0, 1'b0));
         exp_c_q.push_back(model_out(cx, cy, C_HA, C_HF, C_HS, C_VA, C_VF, C_VS, 1'b1, 1'b1));
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         if (exp_a_q.size() == 0) chk("cmp_a_queue", 0, 1);
         else chk("cmp_a", {5'd0, a_fs, a_ls, a_vsync, a_hsync, a_viden, a_vy, a_vx}, {5'd0, exp_a_q.pop_front()});
         if (exp_b_q.size() == 0) chk("cmp_b_queue", 0, 1);
         else chk("cmp_b", {5'd0, b_fs, b_ls, b_vsync, b_hsync, b_viden, b_vy, b_vx}, {5'd0, exp_b_q.pop_front()});
         if (exp_c_q.size() == 0) chk("cmp_c_queue", 0, 1);
         else chk("cmp_c", {5'd0, c_fs, c_ls, c_vsync, c_hsync, c_viden, c_vy, c_vx}, {5'd0, exp_c_q.pop_front()});
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int k, cnt_vid, cnt_hs, first_hs, last_hs, cnt_ls, cnt_vs, vs_y, vs_x, run, vy_before;

      reset  = 1'b1;
      pix_en = 1'b0;
      repeat (3) tick();
      chk("rst_vx", a_vx, 799);
      chk("rst_vy", a_vy, 524);
      chk("rst_viden", a_viden, 0);
      chk("rst_hsync", a_hsync, 1);
      chk("rst_vsync", a_vsync, 1);
      chk("rst_line_start", a_ls, 0);
      chk("rst_frame_start", a_fs, 0);
      chk("rst_c_hsync", c_hsync, 0);
      chk("rst_c_vsync", c_vsync, 0);

      // Released but not enabled: nothing moves
      reset = 1'b0;
      tick(); tick();
      chk("hold_vx", a_vx, 799);
      chk("hold_vy", a_vy, 524);

      pix_en = 1'b1;
      tick();
      chk("first_vx", a_vx, 0);
      chk("first_vy", a_vy, 0);
      chk("first_viden", a_viden, 1);
      chk("first_frame_start", a_fs, 1);
      chk("first_line_start", a_ls, 1);
      chk("first_b_frame_start", b_fs, 1);

      // One full line at default timing
      cnt_vid = 0; cnt_hs = 0; first_hs = -1; last_hs = -1; cnt_ls = 0;
      for (int i = 0; i < 800; i++) begin
         if (a_viden) cnt_vid++;
         if (!a_hsync) begin
            cnt_hs++;
            if (first_hs < 0) first_hs = int'(a_vx);
            last_hs = int'(a_vx);
         end
         if (a_ls) cnt_ls++;
         tick();
      end
      chk("line_viden_cycles", cnt_vid, 640);
      chk("line_hsync_cycles", cnt_hs, 96);
      chk("line_hsync_first_vx", first_hs, 656);
      chk("line_hsync_last_vx", last_hs, 751);
      chk("line_start_count", cnt_ls, 1);
      chk("line_wrap_vx", a_vx, 0);
      chk("line_wrap_vy", a_vy, 1);
      chk("line_wrap_line_start", a_ls, 1);

      // Two whole frames on the tiny raster
      k = 0;
      while (!b_fs && k < 200) begin tick(); k++; end
      chk("b_frame_found", b_fs, 1);
      for (int f = 0; f < 2; f++) begin
         k = 0; cnt_vid = 0; cnt_vs = 0; vs_y = -1; vs_x = -1;
         do begin
            if (b_viden) cnt_vid++;
            if (!b_vsync) begin
               cnt_vs++;
               if (vs_y < 0) begin vs_y = int'(b_vy); vs_x = int'(b_vx); end
            end
            tick();
            k++;
         end while (!b_fs && k < 200);
         chk("b_frame_period", k, 84);
         chk("b_vsync_cycles", cnt_vs, 12);
         chk("b_vsync_start_vy", vs_y, 5);
         chk("b_vsync_start_vx", vs_x, 0);
         chk("b_viden_cycles", cnt_vid, 32);
      end

      // 1-in-3 pixel enable over one default line
      k = 0;
      while (a_vx != 0 && k < 900) begin tick(); k++; end
      chk("div3_align_vx", a_vx, 0);
      vy_before = int'(a_vy);
      cnt_ls = 0; run = 0;
      for (int c = 0; c < 2400; c++) begin
         pix_en = (c % 3 == 2);
         if (a_ls) cnt_ls++;
         if (b_fs) run++;
         else if (run != 0) begin
            chk("div3_b_frame_start_clocks", run, 3);
            run = 0;
         end
         tick();
      end
      chk("div3_line_start_clocks", cnt_ls, 3);
      chk("div3_wrap_vx", a_vx, 0);
      chk("div3_wrap_vy", a_vy, vy_before + 1);
      chk("div3_wrap_line_start", a_ls, 1);
      pix_en = 1'b1;

      // Reset mid-line
      k = 0;
      while (a_vx != 300 && k < 900) begin tick(); k++; end
      chk("midrst_found_vx", a_vx, 300);
      reset = 1'b1;
      tick();
      chk("midrst_vx", a_vx, 799);
      chk("midrst_vy", a_vy, 524);
      chk("midrst_viden", a_viden, 0);
      chk("midrst_frame_start", a_fs, 0);
      reset = 1'b0;
      tick();
      chk("midrst_first_vx", a_vx, 0);
      chk("midrst_first_vy", a_vy, 0);
      chk("midrst_first_frame_start", a_fs, 1);

      // Wide raster, high-active sync
      k = 0;
      while (c_vx != 1023 && k < 1100) begin tick(); k++; end
      chk("c_last_active_vx", c_vx, 1023);
      chk("c_last_active_viden", c_viden, 1);
      chk("c_last_active_hsync", c_hsync, 0);
      tick();
      chk("c_blank_vx", c_vx, 1024);
      chk("c_blank_viden", c_viden, 0);
      k = 0;
      while (c_vx != 1040 && k < 100) begin tick(); k++; end
      chk("c_hsync_start_vx", c_vx, 1040);
      chk("c_hsync_start", c_hsync, 1);
      k = 0;
      while (c_vx != 1136 && k < 200) begin tick(); k++; end
      chk("c_hsync_end_vx", c_vx, 1136);
      chk("c_hsync_end", c_hsync, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
